// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_train_gen
//  Description : Registered pulse-train generator. A start request with a
//                non-zero count emits i_num pulses, each HIGH_W cycles high
//                and separated by LOW_W low cycles. No trailing gap follows
//                the last pulse; o_done strobes in the cycle after it.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                i_start  - start request, sampled every cycle while idle
//                i_num    - pulse count, latched when a start is accepted
//                o_pulse  - pulse train output (registered)
//                o_busy   - high while a train is running (registered)
//                o_done   - one-cycle completion strobe (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
    parameter int HIGH_W = 4,
    parameter int LOW_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);

    // One phase counter serves both phases, so it spans the longer one.
    localparam int c_PH_MAX = (HIGH_W > LOW_W) ? HIGH_W : LOW_W;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    localparam logic [c_PH_W-1:0] c_HIGH_LAST = c_PH_W'(HIGH_W - 1);
    localparam logic [c_PH_W-1:0] c_LOW_LAST  = c_PH_W'(LOW_W - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_PH_W-1:0] r_phase;
    logic [c_PH_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic              r_pulse;
    logic              r_busy;
    logic              r_done;
    logic              w_pulse_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // A zero count is dropped entirely: no busy, no done.
                if (i_start && (i_num != '0)) begin
                    w_state_nxt = c_ST_HIGH;
                    w_phase_nxt = '0;
                    w_rem_nxt   = i_num;
                end
            end
            c_ST_HIGH: begin
                if (r_phase == c_HIGH_LAST) begin
                    w_phase_nxt = '0;
                    // r_rem is at least 1 here, so the decrement never wraps.
                    w_rem_nxt   = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_LOW;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_PH_W'(1);
                end
            end
            c_ST_LOW: begin
                if (r_phase == c_LOW_LAST) begin
                    w_state_nxt = c_ST_HIGH;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + c_PH_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_phase_nxt = '0;
                w_rem_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the next state and then registered so
        // they line up with the state they describe and never glitch.
        w_pulse_nxt = (w_state_nxt == c_ST_HIGH);
        w_busy_nxt  = (w_state_nxt != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_phase <= '0;
            r_rem   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_rem   <= w_rem_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_pulse = r_pulse;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_train_gen
//  Description : Self-checking bench for pulse_train_gen. Three instances
//                with different parameter sets share clock and reset; an
//                arithmetic reference model predicts each output per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [7:0] num0;
    logic [7:0] num1;
    logic [3:0] num2;
    logic [2:0] pulse;
    logic [2:0] busy;
    logic [2:0] done;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    // Instance 0: HIGH_W=4, LOW_W=4, CNT_W=8
    pulse_train_gen #(.HIGH_W(4), .LOW_W(4), .CNT_W(8)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start[0]),
        .i_num   (num0),
        .o_pulse (pulse[0]),
        .o_busy  (busy[0]),
        .o_done  (done[0])
    );

    // Instance 1: HIGH_W=2, LOW_W=3, CNT_W=8
    pulse_train_gen #(.HIGH_W(2), .LOW_W(3), .CNT_W(8)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start[1]),
        .i_num   (num1),
        .o_pulse (pulse[1]),
        .o_busy  (busy[1]),
        .o_done  (done[1])
    );

    // Instance 2: HIGH_W=1, LOW_W=1, CNT_W=4
    pulse_train_gen #(.HIGH_W(1), .LOW_W(1), .CNT_W(4)) u_dut_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start[2]),
        .i_num   (num2),
        .o_pulse (pulse[2]),
        .o_busy  (busy[2]),
        .o_done  (done[2])
    );

    // ------------------------------------------------------------------
    // Reference model: a train accepted at edge t with count N occupies
    // periods d = 0 .. N*(H+L)-L-1 after that edge; within it the pulse
    // is high when d mod (H+L) < H. Period d = span is the done cycle.
    // ------------------------------------------------------------------
    int cyc;
    int t_st [3];
    int n_st [3];
    bit act  [3];

    function automatic int hw(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int lw(int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int num_of(int i);
        case (i)
            0:       return int'(num0);
            1:       return int'(num1);
            default: return int'(num2);
        endcase
    endfunction

    function automatic int span_of(int i);
        return n_st[i] * (hw(i) + lw(i)) - lw(i);
    endfunction

    function automatic bit model_busy(int i, int c);
        int d;
        d = c - t_st[i];
        return act[i] && (d >= 0) && (d < span_of(i));
    endfunction

    // Expected {pulse, busy, done} for the current period.
    function automatic logic [2:0] exp_out(int i);
        int d;
        int per;
        int span;
        if (!act[i]) return 3'b000;
        per  = hw(i) + lw(i);
        span = span_of(i);
        d    = cyc - t_st[i];
        if (d < 0) return 3'b000;
        if (d < span) return {((d % per) < hw(i)) ? 1'b1 : 1'b0, 1'b1, 1'b0};
        if (d == span) return 3'b001;
        return 3'b000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int i = 0; i < 3; i++) act[i] <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 3; i++) begin
                if (start[i] && (num_of(i) != 0) && !model_busy(i, cyc)) begin
                    act[i]  <= 1'b1;
                    t_st[i] <= cyc + 1;
                    n_st[i] <= num_of(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        start = 3'b000;
        num0  = 8'd0;
        num1  = 8'd0;
        num2  = 4'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pulse, busy, done} !== 9'b0) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", {pulse, busy, done}, 9'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [2:0] obs;
        logic [2:0] req;
        start[0] = 1'b1;
        num0     = 8'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            obs = {pulse[0], busy[0], done[0]};
            req = {(k < 4) ? 1'b1 : 1'b0, (k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0};
            vectors++;
            if (obs !== req) begin
                fails++;
                $display("FAIL single_timing k=%0d: got %b expected %b", k, obs, req);
            end
            vectors++;
            if (obs !== exp_out(0)) begin
                fails++;
                $display("FAIL single_model k=%0d: got %b expected %b", k, obs, exp_out(0));
            end
            start[0] = 1'b0;
        end
    endtask

    task automatic test_train;
        logic [2:0] obs;
        logic [2:0] req;
        int         rises;
        logic       prev;
        rises    = 0;
        prev     = 1'b0;
        start[1] = 1'b1;
        num1     = 8'd3;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs = {pulse[1], busy[1], done[1]};
            req = {((k < 12) && ((k % 5) < 2)) ? 1'b1 : 1'b0,
                   (k < 12) ? 1'b1 : 1'b0,
                   (k == 12) ? 1'b1 : 1'b0};
            vectors++;
            if (obs !== req) begin
                fails++;
                $display("FAIL train_timing k=%0d: got %b expected %b", k, obs, req);
            end
            if (pulse[1] && !prev) rises++;
            prev     = pulse[1];
            start[1] = 1'b0;
        end
        vectors++;
        if (rises != 3) begin
            fails++;
            $display("FAIL train_rises: got %0d expected %0d", rises, 3);
        end
    endtask

    task automatic test_ignored;
        logic [2:0] obs;
        int         n;
        int         span;
        int         rises;
        int         done_at;
        logic       prev;
        // Zero-count requests held for several cycles.
        start[0] = 1'b1;
        num0     = 8'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            obs = {pulse[0], busy[0], done[0]};
            vectors++;
            if (obs !== 3'b000) begin
                fails++;
                $display("FAIL ignore_zero k=%0d: got %b expected %b", k, obs, 3'b000);
            end
        end
        start[0] = 1'b0;
        // Random retriggers and count changes during a running train.
        n        = $urandom_range(2, 4);
        span     = n * 5 - 3;
        rises    = 0;
        done_at  = -1;
        prev     = 1'b0;
        start[1] = 1'b1;
        num1     = 8'(n);
        for (int k = 0; k < span + 4; k++) begin
            @(negedge clk);
            obs = {pulse[1], busy[1], done[1]};
            vectors++;
            if (obs !== exp_out(1)) begin
                fails++;
                $display("FAIL ignore_busy k=%0d: got %b expected %b", k, obs, exp_out(1));
            end
            if (pulse[1] && !prev) rises++;
            if (done[1] && done_at < 0) done_at = k;
            prev     = pulse[1];
            start[1] = (k < span) ? 1'($urandom) : 1'b0;
            num1     = 8'($urandom);
        end
        vectors++;
        if (rises != n || done_at != span) begin
            fails++;
            $display("FAIL ignore_len: got rises=%0d done_at=%0d expected rises=%0d done_at=%0d",
                     rises, done_at, n, span);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] obs;
        logic [2:0] req;
        start[2] = 1'b1;
        num2     = 4'd2;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs = {pulse[2], busy[2], done[2]};
            req = {((k % 4) == 0 || (k % 4) == 2) ? 1'b1 : 1'b0,
                   ((k % 4) != 3) ? 1'b1 : 1'b0,
                   ((k % 4) == 3) ? 1'b1 : 1'b0};
            vectors++;
            if (obs !== req) begin
                fails++;
                $display("FAIL b2b_pattern k=%0d: got %b expected %b", k, obs, req);
            end
            vectors++;
            if (obs !== exp_out(2)) begin
                fails++;
                $display("FAIL b2b_model k=%0d: got %b expected %b", k, obs, exp_out(2));
            end
        end
        start[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset;
        logic [2:0] obs;
        logic [2:0] req;
        start[0] = 1'b1;
        num0     = 8'($urandom_range(2, 5));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            obs = {pulse[0], busy[0], done[0]};
            vectors++;
            if (obs !== exp_out(0)) begin
                fails++;
                $display("FAIL arst_pre k=%0d: got %b expected %b", k, obs, exp_out(0));
            end
            start[0] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pulse, busy, done} !== 9'b0) begin
            fails++;
            $display("FAIL arst_immediate: got %b expected %b", {pulse, busy, done}, 9'b0);
        end
        @(negedge clk);
        vectors++;
        if ({pulse, busy, done} !== 9'b0) begin
            fails++;
            $display("FAIL arst_held: got %b expected %b", {pulse, busy, done}, 9'b0);
        end
        rst_n    = 1'b1;
        start[0] = 1'b1;
        num0     = 8'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            obs = {pulse[0], busy[0], done[0]};
            req = {(k < 4) ? 1'b1 : 1'b0, (k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0};
            vectors++;
            if (obs !== req) begin
                fails++;
                $display("FAIL arst_after k=%0d: got %b expected %b", k, obs, req);
            end
            start[0] = 1'b0;
        end
    endtask

    task automatic test_max_count;
        logic [2:0] obs;
        int         rises;
        int         dones;
        logic       prev;
        rises    = 0;
        dones    = 0;
        prev     = 1'b0;
        start[2] = 1'b1;
        num2     = 4'd15;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            obs = {pulse[2], busy[2], done[2]};
            vectors++;
            if (obs !== exp_out(2) || done[2] !== ((k == 29) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL max_model k=%0d: got %b expected %b", k, obs, exp_out(2));
            end
            if (pulse[2] && !prev) rises++;
            if (done[2]) dones++;
            prev     = pulse[2];
            start[2] = 1'b0;
        end
        vectors++;
        if (rises != 15 || dones != 1) begin
            fails++;
            $display("FAIL max_count: got rises=%0d dones=%0d expected rises=15 dones=1", rises, dones);
        end
    endtask

    task automatic test_random;
        logic [2:0] obs;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                obs = {pulse[i], busy[i], done[i]};
                vectors++;
                if (obs !== exp_out(i)) begin
                    fails++;
                    $display("FAIL random dut=%0d k=%0d: got %b expected %b", i, k, obs, exp_out(i));
                end
            end
            start = 3'($urandom);
            num0  = 8'($urandom_range(0, 3));
            num1  = 8'($urandom_range(0, 3));
            num2  = 4'($urandom);
        end
        start = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_train();
        test_ignored();
        test_back_to_back();
        test_async_reset();
        test_max_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pulse_train_gen.md
# pulse_train_gen

Registered pulse generator: one start request produces a train of `i_num` pulses on `o_pulse`. Each pulse is high for `HIGH_W` cycles and is followed by a gap of `LOW_W` cycles. This block is the generating end of the edge/pulse utilities. Its output feeds the pulse edge detectors and is used to drive test stimulus and strobes into downstream logic.

## Interface
- `HIGH_W`, default 4: high time of each pulse in clk cycles; must be ≥ 1.
- `LOW_W`, default 4: low gap between consecutive pulses in clk cycles; must be ≥ 1.
- `CNT_W`, default 8: width of the pulse-count input.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  start request; level-sampled every cycle.
- `i_num`  in  CNT_W  number of pulses; sampled only in the cycle a start is accepted.
- `o_pulse`  out  1  pulse train output; registered.
- `o_busy`  out  1  high while a train is in progress; registered.
- `o_done`  out  1  one-cycle strobe when a train completes; registered.

## Operation
- FSM states: IDLE, HIGH, LOW.
- Internal phase counter covers max(HIGH_W, LOW_W) cycles.
- Internal remaining-pulse counter is CNT_W bits.
- **IDLE:**
  - If `i_start`=1 and `i_num`≠0: latch `i_num` into the remaining counter and go to HIGH.
  - If `i_start`=1 and `i_num`=0: ignore the request. Stay in IDLE; no busy, no done.
- **HIGH:**
  - `o_pulse`=1 for exactly HIGH_W cycles.
  - At the end of the phase, decrement the remaining counter.
  - If pulses remain, go to LOW.
  - Otherwise go to IDLE and assert `o_done` for one cycle.
- **LOW:**
  - `o_pulse`=0 for exactly LOW_W cycles, then go to HIGH.
  - No trailing LOW phase follows the last pulse.
- `o_busy`=1 in HIGH and LOW; 0 in IDLE.
- `i_start` and `i_num` are ignored while busy. There is no retrigger and no extension of a running train.
- `i_num` may change freely after acceptance without affecting the running train.
- `i_num` = 2^CNT_W−1 produces the full count of pulses. The remaining counter must not wrap to a larger value.

## Timing
- Reset values: `o_pulse`=0, `o_busy`=0, `o_done`=0, FSM=IDLE, counters=0.
- Reset assertion clears everything asynchronously, mid-train included. A partially emitted pulse is cut short with no `o_done`.
- Start accepted at rising edge t:
  - First pulse occupies cycles t+1 … t+HIGH_W.
  - Pulse k (counting from 0) starts at t+1+k·(HIGH_W+LOW_W).
  - Last high cycle is t+N·HIGH_W+(N−1)·LOW_W, where N = latched `i_num`.
  - `o_done`=1 in the single cycle after the last high cycle. `o_busy`=0 in that same cycle.
- `o_busy` rises together with the first `o_pulse` and falls together with the last one.
- Latency from accepted start to first `o_pulse`: 1 cycle.
- The `o_done` cycle is an IDLE cycle, so `i_start` there is accepted. A new train then begins the next cycle, leaving a minimum 1-cycle low gap between trains.
- All outputs are glitch-free register outputs. There is no combinational path from the inputs.

## Test plan
- **Single pulse.** HIGH_W=4, LOW_W=4, `i_num`=1, start at t → `o_pulse`/`o_busy` high t+1..t+4, `o_done` at t+5 only, then idle.
- **Train.** HIGH_W=2, LOW_W=3, `i_num`=3, start at t → `o_pulse` high t+1..2, t+6..7, t+11..12; `o_busy` t+1..t+12; `o_done` at t+13; exactly 3 rising edges.
- **Ignored requests.**
  - `i_num`=0 with `i_start` held 5 cycles → all outputs stay 0.
  - `i_start` pulsed and `i_num` changed mid-train → train length and spacing unchanged.
- **Back-to-back.** HIGH_W=LOW_W=1, `i_num`=2, `i_start` held high continuously → pattern 1,0,1,(done=1, pulse 0),1,0,1,… repeating with period 4.
- **Async reset mid-train.** Assert `rst_n`=0 between clock edges during a HIGH phase → `o_pulse`/`o_busy` drop immediately, no `o_done`; after release, a fresh start behaves as in the single-pulse case.
- **Max count.** CNT_W=4, `i_num`=15, HIGH_W=LOW_W=1 → exactly 15 pulses, `o_done` once, no counter wrap.
